// File: rtl/branch_predictor.sv
`default_nettype none
// branch_predictor: gshare predictor with a speculative GHR, mispredict recovery and counters.
// Rev 1.0
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pc_F,
  input  logic                  branch_F,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  prediction_F,
  output logic [INDEX_BITS-1:0] pred_index_F,
  output logic [GHR_BITS-1:0]   pred_ghr_F,
  input  logic                  update_en_E,
  input  logic [INDEX_BITS-1:0] update_index_E,
  input  logic [GHR_BITS-1:0]   update_ghr_E,
  input  logic                  prediction_E,
  input  logic                  actual_outcome_E,
  output logic [15:0]           branch_count,
  output logic [15:0]           mispredict_count
);

  localparam int          ENTRIES = 1 << INDEX_BITS;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0]            pht [ENTRIES];
  logic [GHR_BITS-1:0]   ghr;
  logic [GHR_BITS-1:0]   recover_ghr;
  logic [GHR_BITS-1:0]   spec_ghr;
  logic [INDEX_BITS-1:0] idx;
  logic                  mispredict;
  logic                  fetch_shift;
  logic                  unused_pc;

  assign idx          = pc_F[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  assign prediction_F = branch_F & pht[idx][1];
  assign pred_index_F = idx;
  assign pred_ghr_F   = ghr;
  assign unused_pc    = ^{pc_F[31:INDEX_BITS+2], pc_F[1:0]};

  assign mispredict  = update_en_E & (prediction_E != actual_outcome_E);
  assign fetch_shift = branch_F & ~stall & ~flush;

  generate
    if (GHR_BITS == 1) begin : g_ghr_single
      logic unused_ghr;
      assign recover_ghr = actual_outcome_E;
      assign spec_ghr    = prediction_F;
      assign unused_ghr  = ^update_ghr_E;
    end else begin : g_ghr_multi
      assign recover_ghr = {update_ghr_E[GHR_BITS-2:0], actual_outcome_E};
      assign spec_ghr    = {ghr[GHR_BITS-2:0], prediction_F};
    end
  endgenerate

  // Training writes the counter Fetch may be reading; Fetch sees the old value this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    end else if (update_en_E) begin
      if (actual_outcome_E && (pht[update_index_E] != 2'b11))
        pht[update_index_E] <= pht[update_index_E] + 2'b01;
      else if (!actual_outcome_E && (pht[update_index_E] != 2'b00))
        pht[update_index_E] <= pht[update_index_E] - 2'b01;
    end
  end

  // Recovery outranks the speculative shift: the Fetch branch is being squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ghr <= '0;
    else if (mispredict)  ghr <= recover_ghr;
    else if (fetch_shift) ghr <= spec_ghr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_en_E && (branch_count != CNT_MAX))
        branch_count <= branch_count + 16'd1;
      if (mispredict && (mispredict_count != CNT_MAX))
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// tb_branch_predictor: directed self-checking bench for the gshare branch predictor.
// Rev 1.0
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_F;
  logic        branch_F;
  logic        stall;
  logic        flush;
  logic        prediction_F;
  logic [5:0]  pred_index_F;
  logic [3:0]  pred_ghr_F;
  logic        update_en_E;
  logic [5:0]  update_index_E;
  logic [3:0]  update_ghr_E;
  logic        prediction_E;
  logic        actual_outcome_E;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  branch_predictor #(.INDEX_BITS(6), .GHR_BITS(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_F             (pc_F),
    .branch_F         (branch_F),
    .stall            (stall),
    .flush            (flush),
    .prediction_F     (prediction_F),
    .pred_index_F     (pred_index_F),
    .pred_ghr_F       (pred_ghr_F),
    .update_en_E      (update_en_E),
    .update_index_E   (update_index_E),
    .update_ghr_E     (update_ghr_E),
    .prediction_E     (prediction_E),
    .actual_outcome_E (actual_outcome_E),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pc_F             = 32'h0;
    branch_F         = 1'b0;
    stall            = 1'b0;
    flush            = 1'b0;
    update_en_E      = 1'b0;
    update_index_E   = 6'd0;
    update_ghr_E     = 4'd0;
    prediction_E     = 1'b0;
    actual_outcome_E = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    branch_F = 1'b1;
    pc_F = 32'h1234_5678;
    #1;
    total_cnt++;
    if (prediction_F !== 1'b0) $display("FAIL reset_pred: got %b expected 0", prediction_F);
    else pass_cnt++;
    total_cnt++;
    if (pred_ghr_F !== 4'd0) $display("FAIL reset_ghr: got %h expected 0", pred_ghr_F);
    else pass_cnt++;
    total_cnt++;
    if (pred_index_F !== 6'd30) $display("FAIL reset_index: got %0d expected 30", pred_index_F);
    else pass_cnt++;
    total_cnt++;
    if (branch_count !== 16'd0 || mispredict_count !== 16'd0)
      $display("FAIL reset_counts: got %h/%h expected 0000/0000", branch_count, mispredict_count);
    else pass_cnt++;
    tick();
    branch_F = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_train_taken();
    do_reset();
    update_en_E = 1'b1;
    update_index_E = 6'd5;
    update_ghr_E = 4'd0;
    prediction_E = 1'b0;
    actual_outcome_E = 1'b1;
    tick();
    tick();
    update_en_E = 1'b0;
    // Mispredicts left ghr=0001; four not-taken fetch predictions clear it.
    branch_F = 1'b1;
    pc_F = 32'h100;
    for (int i = 0; i < 4; i++) tick();
    branch_F = 1'b0;
    #1;
    total_cnt++;
    if (pred_ghr_F !== 4'd0) $display("FAIL train_ghr_clear: got %h expected 0", pred_ghr_F);
    else pass_cnt++;
    branch_F = 1'b1;
    pc_F = 32'h14;
    #1;
    total_cnt++;
    if (prediction_F !== 1'b1) $display("FAIL train_pred: got %b expected 1", prediction_F);
    else pass_cnt++;
    total_cnt++;
    if (pred_index_F !== 6'd5) $display("FAIL train_index: got %0d expected 5", pred_index_F);
    else pass_cnt++;
    total_cnt++;
    if (branch_count !== 16'd2) $display("FAIL train_branch_count: got %0d expected 2", branch_count);
    else pass_cnt++;
    total_cnt++;
    if (mispredict_count !== 16'd2) $display("FAIL train_mispredict_count: got %0d expected 2", mispredict_count);
    else pass_cnt++;
    branch_F = 1'b0;
  endtask

  task automatic test_hysteresis();
    do_reset();
    update_en_E = 1'b1;
    update_index_E = 6'd9;
    prediction_E = 1'b1;
    actual_outcome_E = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    prediction_E = 1'b0;
    actual_outcome_E = 1'b0;
    tick();
    update_en_E = 1'b0;
    branch_F = 1'b1;
    pc_F = 32'h24;
    #1;
    total_cnt++;
    if (prediction_F !== 1'b1) $display("FAIL hyst_one_nt: got %b expected 1", prediction_F);
    else pass_cnt++;
    branch_F = 1'b0;
    update_en_E = 1'b1;
    tick();
    update_en_E = 1'b0;
    branch_F = 1'b1;
    #1;
    total_cnt++;
    if (prediction_F !== 1'b0) $display("FAIL hyst_two_nt: got %b expected 0", prediction_F);
    else pass_cnt++;
    total_cnt++;
    if (mispredict_count !== 16'd0) $display("FAIL hyst_no_mispredict: got %0d expected 0", mispredict_count);
    else pass_cnt++;
    branch_F = 1'b0;
  endtask

  task automatic test_ghr_recover();
    do_reset();
    update_en_E = 1'b1;
    update_index_E = 6'd63;
    update_ghr_E = 4'b0111;
    prediction_E = 1'b0;
    actual_outcome_E = 1'b1;
    tick();
    update_en_E = 1'b0;
    total_cnt++;
    if (pred_ghr_F !== 4'b1111) $display("FAIL ghr_recover_first: got %b expected 1111", pred_ghr_F);
    else pass_cnt++;
    branch_F = 1'b1;
    pc_F = 32'h100;
    #1;
    total_cnt++;
    if (prediction_F !== 1'b0) $display("FAIL ghr_spec_pred: got %b expected 0", prediction_F);
    else pass_cnt++;
    tick();
    tick();
    tick();
    total_cnt++;
    if (pred_ghr_F !== 4'b1000) $display("FAIL ghr_spec_shift: got %b expected 1000", pred_ghr_F);
    else pass_cnt++;
    // Mispredict with a Fetch branch present: recovery wins.
    update_en_E = 1'b1;
    update_index_E = 6'd62;
    update_ghr_E = 4'b0110;
    prediction_E = 1'b0;
    actual_outcome_E = 1'b1;
    tick();
    update_en_E = 1'b0;
    branch_F = 1'b0;
    #1;
    total_cnt++;
    if (pred_ghr_F !== 4'b1101) $display("FAIL ghr_recover: got %b expected 1101", pred_ghr_F);
    else pass_cnt++;
    total_cnt++;
    if (mispredict_count !== 16'd2 || branch_count !== 16'd2)
      $display("FAIL ghr_counts: got %0d/%0d expected 2/2", branch_count, mispredict_count);
    else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    do_reset();
    update_en_E = 1'b1;
    update_index_E = 6'd40;
    update_ghr_E = 4'd0;
    prediction_E = 1'b0;
    actual_outcome_E = 1'b1;
    tick();
    update_en_E = 1'b0;
    branch_F = 1'b1;
    stall = 1'b1;
    pc_F = 32'hA4;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (prediction_F !== 1'b1 || pred_ghr_F !== 4'b0001)
        $display("FAIL stall_hold_%0d: got pred=%b ghr=%b expected pred=1 ghr=0001", i, prediction_F, pred_ghr_F);
      else pass_cnt++;
      tick();
    end
    stall = 1'b0;
    tick();
    branch_F = 1'b0;
    #1;
    total_cnt++;
    if (pred_ghr_F !== 4'b0011) $display("FAIL stall_release_shift: got %b expected 0011", pred_ghr_F);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (pred_ghr_F !== 4'b0011) $display("FAIL stall_single_shift: got %b expected 0011", pred_ghr_F);
    else pass_cnt++;
    branch_F = 1'b1;
    flush = 1'b1;
    tick();
    branch_F = 1'b0;
    flush = 1'b0;
    #1;
    total_cnt++;
    if (pred_ghr_F !== 4'b0011) $display("FAIL flush_no_shift: got %b expected 0011", pred_ghr_F);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    update_en_E = 1'b1;
    update_index_E = 6'd5;
    prediction_E = 1'b1;
    actual_outcome_E = 1'b1;
    branch_F = 1'b1;
    pc_F = 32'h14;
    #1;
    total_cnt++;
    if (prediction_F !== 1'b0) $display("FAIL same_cycle_old: got %b expected 0", prediction_F);
    else pass_cnt++;
    tick();
    update_en_E = 1'b0;
    #1;
    total_cnt++;
    if (prediction_F !== 1'b1) $display("FAIL same_cycle_next: got %b expected 1", prediction_F);
    else pass_cnt++;
    // Asynchronous reset mid-operation clears state without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (prediction_F !== 1'b0 || branch_count !== 16'd0)
      $display("FAIL async_reset: got pred=%b count=%0d expected pred=0 count=0", prediction_F, branch_count);
    else pass_cnt++;
    tick();
    branch_F = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    update_en_E = 1'b1;
    update_index_E = 6'd7;
    prediction_E = 1'b0;
    actual_outcome_E = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    total_cnt++;
    if (mispredict_count !== 16'hFFFE) $display("FAIL sat_pre: got %h expected fffe", mispredict_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mispredict_count !== 16'hFFFF || branch_count !== 16'hFFFF)
      $display("FAIL sat_reach: got %h/%h expected ffff/ffff", branch_count, mispredict_count);
    else pass_cnt++;
    tick();
    update_en_E = 1'b0;
    total_cnt++;
    if (mispredict_count !== 16'hFFFF || branch_count !== 16'hFFFF)
      $display("FAIL sat_hold: got %h/%h expected ffff/ffff", branch_count, mispredict_count);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_train_taken();
    test_hysteresis();
    test_ghr_recover();
    test_stall_flush();
    test_same_cycle();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Gshare conditional-branch predictor for the five-stage pipeline. It supplies the `prediction` bit that the hazard control unit compares against `actual_outcome`, and it is trained by the resolved outcome returned from the Execute stage. Fetch gets a combinational prediction for the current PC. The pipeline carries the returned PHT index, the history snapshot and the prediction down to Execute. Mispredicts restore the speculative global history register (GHR) and are counted for performance monitoring.

## Interface
- `INDEX_BITS`, 6: log2 of the number of pattern history table (PHT) entries.
- `GHR_BITS`, 4: global history length; must be 1..`INDEX_BITS`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_F`  in  32  PC of the instruction in Fetch.
- `branch_F`  in  1  predecoded: the Fetch instruction is a conditional branch.
- `stall`  in  1  Fetch/Decode stall from the hazard control unit.
- `flush`  in  1  Fetch/Decode flush from the hazard control unit.
- `prediction_F`  out  1  predicted taken; 0 when `branch_F`=0.
- `pred_index_F`  out  `INDEX_BITS`  PHT index used for this prediction.
- `pred_ghr_F`  out  `GHR_BITS`  GHR value before this prediction is shifted in.
- `update_en_E`  in  1  a conditional branch is resolved in Execute this cycle.
- `update_index_E`  in  `INDEX_BITS`  `pred_index_F` carried down to Execute.
- `update_ghr_E`  in  `GHR_BITS`  `pred_ghr_F` carried down to Execute.
- `prediction_E`  in  1  `prediction_F` carried down to Execute.
- `actual_outcome_E`  in  1  resolved direction, 1 = taken.
- `branch_count`  out  16  resolved branches, saturating.
- `mispredict_count`  out  16  mispredicted branches, saturating.

## Operation
- **Index**
  - `idx = pc_F[INDEX_BITS+1:2] XOR {zeros, ghr}`.
  - The GHR is zero-extended on the MSB side to `INDEX_BITS`.
- **PHT**
  - `2^INDEX_BITS` two-bit saturating counters.
  - States: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - `prediction_F = branch_F & PHT[idx][1]`.
- **Mispredict**
  - `mispredict = update_en_E & (prediction_E != actual_outcome_E)`.
- **PHT training**, when `update_en_E`=1:
  - `PHT[update_index_E]` increments if `actual_outcome_E`=1, otherwise decrements.
  - Saturates at 11 and 00.
  - Training is independent of `stall` and `flush`.
- **GHR update**, evaluated in priority order each edge:
  1. If `mispredict`: `ghr <= {update_ghr_E[GHR_BITS-2:0], actual_outcome_E}`. Recovery; when `GHR_BITS`=1, `ghr <= actual_outcome_E`.
  2. Else if `branch_F & ~stall & ~flush`: `ghr <= {ghr[GHR_BITS-2:0], prediction_F}`. Speculative shift.
  3. Otherwise `ghr` holds.
- **Counters**
  - `branch_count` increments on `update_en_E`.
  - `mispredict_count` increments on `mispredict`.
  - Both hold at 16'hFFFF.
- **Same-cycle read/write**: a Fetch read of the index being trained returns the pre-update counter. There is no bypass.
- **Contract**: `update_*_E` must be the values produced for the same dynamic branch. The predictor does not check this.

## Timing
- **Reset** (asynchronous, while `rst_n`=0):
  - All PHT entries = 01.
  - `ghr` = 0.
  - `branch_count` = `mispredict_count` = 0.
  - Therefore `prediction_F` = 0 and `pred_ghr_F` = 0.
  - `pred_index_F` = `pc_F[INDEX_BITS+1:2]`.
- **Reset mid-operation**: all state clears immediately. The first prediction after release uses the reset state.
- **Prediction latency**: `prediction_F`, `pred_index_F` and `pred_ghr_F` are combinational from `pc_F`, `branch_F` and registered state, with zero cycles of latency.
- **Update latency**:
  - A PHT update is visible to Fetch on the cycle after the `update_en_E` edge.
  - GHR recovery is visible on the cycle after the mispredict edge.
- **Stall**: when `stall`=1, `prediction_F` stays stable for the held PC. The GHR does not shift again when the stall releases, because the shift happens only on the non-stalled edge.
- **Simultaneous events**: a mispredict and a Fetch branch in the same cycle means recovery wins. The Fetch instruction is being flushed and contributes no shift.

## Test plan
- **Reset**: assert `rst_n`=0 with `branch_F`=1, any PC → `prediction_F`=0, both counters 0, `pred_ghr_F`=0.
- **Train to taken**:
  - Stimulus: `INDEX_BITS`=6, two `update_en_E` pulses at `update_index_E`=5 with `actual`=1 and `prediction_E`=0. Then set `ghr`=0 and `pc_F`=0x14.
  - Response: `prediction_F`=1, `branch_count`=2, `mispredict_count`=2.
- **Hysteresis**: four taken updates at index 9, then one not-taken update → index 9 still predicts 1. A second not-taken update → predicts 0.
- **GHR speculate/recover**:
  - Three Fetch branches, unstalled, each predicting 0 → `ghr`=0000.
  - Then a mispredict with `update_ghr_E`=4'b0110 and `actual`=1 → next-cycle `pred_ghr_F`=4'b1101.
- **Stall/flush gating**: `branch_F`=1 held with `stall`=1 for 3 cycles, then released → exactly one shift. `branch_F`=1 with `flush`=1 → no shift.
- **Same-cycle hazard and saturation**:
  - Training index 5 from 01 to 10 while Fetch reads index 5 → `prediction_F`=0 that cycle, 1 the next.
  - Preload `mispredict_count` to 16'hFFFF, then apply a mispredict → the count stays at 16'hFFFF.
